// File: rtl/wb_timeout_bridge.sv
// Registered single-transfer Wishbone bridge with a bounded-wait timeout that answers a hung peripheral with ERR.
// Optional status counters are enabled by defining WB_TIMEOUT_BRIDGE_STATUS_EN.
module wb_timeout_bridge #(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                       clk,
  input  logic                       rstn,
  // upstream side (from interconnect)
  input  logic                       s_cyc,
  input  logic                       s_stb,
  input  logic                       s_we,
  input  logic [WB_ADDR_WIDTH-1:0]   s_adr,
  input  logic [WB_DATA_WIDTH-1:0]   s_dat_w,
  input  logic [WB_DATA_WIDTH/8-1:0] s_sel,
  output logic                       s_ack,
  output logic                       s_err,
  output logic [WB_DATA_WIDTH-1:0]   s_dat_r,
  // downstream side (to peripheral)
  output logic                       m_cyc,
  output logic                       m_stb,
  output logic                       m_we,
  output logic [WB_ADDR_WIDTH-1:0]   m_adr,
  output logic [WB_DATA_WIDTH-1:0]   m_dat_w,
  output logic [WB_DATA_WIDTH/8-1:0] m_sel,
  output logic [2:0]                 m_cti,
  output logic [1:0]                 m_bte,
`ifdef WB_TIMEOUT_BRIDGE_STATUS_EN
  output logic [15:0]                timeout_count,
  output logic [WB_ADDR_WIDTH-1:0]   last_timeout_adr,
`endif
  input  logic                       m_ack,
  input  logic                       m_err,
  input  logic [WB_DATA_WIDTH-1:0]   m_dat_r
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             ack_flag, err_flag;
  logic             accept, abort, got_ack, got_err, timed_out, done;

  // Bursts are always split into classic single transfers downstream.
  assign m_cti = 3'b000;
  assign m_bte = 2'b00;

  assign s_ack = ack_flag & s_cyc;
  assign s_err = err_flag & s_cyc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    abort      = 1'b0;
    got_ack    = 1'b0;
    got_err    = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        if (s_cyc && s_stb) begin
          accept     = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        // An upstream abort beats any response; ACK beats ERR beats timeout.
        if (!s_cyc) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (m_stb && m_ack) begin
          got_ack    = 1'b1;
          state_next = RESP;
        end else if (m_stb && m_err) begin
          got_err    = 1'b1;
          state_next = RESP;
        end else if (TIMEOUT_CYCLES != 0 && wait_cnt == TERM_CNT) begin
          timed_out  = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign done = abort | got_ack | got_err | timed_out;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_cyc    <= 1'b0;
      m_stb    <= 1'b0;
      m_we     <= 1'b0;
      m_adr    <= '0;
      m_dat_w  <= '0;
      m_sel    <= '0;
      s_dat_r  <= '0;
      ack_flag <= 1'b0;
      err_flag <= 1'b0;
      wait_cnt <= '0;
    end else begin
      ack_flag <= got_ack;
      err_flag <= got_err | timed_out;
      if (accept) begin
        m_cyc    <= 1'b1;
        m_stb    <= 1'b1;
        m_we     <= s_we;
        m_adr    <= s_adr;
        m_dat_w  <= s_dat_w;
        m_sel    <= s_sel;
        wait_cnt <= '0;
      end
      if (done) begin
        m_cyc <= 1'b0;
        m_stb <= 1'b0;
      end
      if (got_ack || got_err) s_dat_r <= m_dat_r;
      if (timed_out)          s_dat_r <= '0;
      // Saturate rather than wrap so a disabled timeout never aliases.
      if (state == REQ && !done && wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
    end
  end

`ifdef WB_TIMEOUT_BRIDGE_STATUS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      timeout_count    <= '0;
      last_timeout_adr <= '0;
    end else if (timed_out) begin
      if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
      last_timeout_adr <= m_adr;
    end
  end
`endif

endmodule
